onehot_pulse_decoder: RTL and testbench
=======================================

# onehot_pulse_decoder

Sequential N-to-2^N decoder that turns an encoded index plus valid into a one-hot output pulse held for a fixed number of cycles. It is the inverse of the lab's 4-to-2 priority-free encoder: a valid/ready request stream goes in, and a registered, stretched one-hot strobe comes out to drive LEDs or per-channel enables. It sits downstream of the encoder and closes the encode/decode loop in the lab2 test system.

## Interface
- `N`, default 2: width of the encoded index; the output is 2^N bits wide.
- `HOLD`, default 4: number of cycles each one-hot output is held, legal range 1..255.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_valid`, input, 1: request present.
- `in_code`, input, N: index to decode; sampled only on accept.
- `in_ready`, output, 1: block can accept; a transfer occurs on `in_valid && in_ready` at a rising edge.
- `out`, output, 2^N: registered one-hot (bit `in_code` set), or all-zero when idle.
- `out_valid`, output, 1: high while `out` holds a decoded value.
- `busy`, output, 1: equal to `out_valid`; kept separate so status wiring is stable across configurations.

## Operation
- States:
  - IDLE: `out`=0, `out_valid`=0, `in_ready`=1.
  - HOLD: `out` = one-hot of the latched code, `out_valid`=1.
- IDLE, accept → HOLD. On the accept edge, `out` <= 1<<`in_code`, and the down-counter `cnt` <= HOLD-1.
- HOLD, `cnt`≠0 → HOLD with `cnt` decremented. `in_ready`=0.
- HOLD, `cnt`=0 → IDLE. `out` <= 0 and `out_valid` <= 0 at the next edge, unless a back-to-back accept occurs (see Configuration).
- `in_valid` asserted while `in_ready`=0 is ignored. The requester must hold the request; nothing is dropped silently.
- HOLD=1: the output is a single-cycle pulse. `cnt` is loaded with 0, so the block returns to IDLE after one cycle.
- Counter width is $clog2(HOLD) with a minimum of 1 bit. The counter never wraps: decrement happens only when `cnt`≠0.
- `in_code` is always in range for power-of-two outputs, so no invalid-code path exists.
- Reset values: `out`=0, `out_valid`=0, `busy`=0, `cnt`=0, state=IDLE. `in_ready` is 1 after reset because it is combinational from state.
- Reset asserted mid-HOLD clears `out` immediately (asynchronously). It does not wait for the clock.

## Timing
- Latency: `out` changes on the same edge that accepts the request, so it is visible one cycle after `in_valid` is first seen high with `in_ready`=1.
- Each accepted code is visible for exactly HOLD cycles.
- Without back-to-back, there is at least one idle cycle (`out`=0) between consecutive strobes, giving a throughput of one request per HOLD+1 cycles.
- `in_ready` is combinational from state and `cnt` only. It never depends on `in_valid`, so there is no combinational loop with the requester.

## Configuration
- Macro: `ONEHOT_DEC_BACK2BACK_EN`.
- Defined:
  - `in_ready`=1 also in HOLD when `cnt`=0.
  - An accept there reloads `out` with the new one-hot code and `cnt` with HOLD-1, with no zero gap.
  - Throughput is one request per HOLD cycles.
- Undefined: `in_ready`=1 only in IDLE, giving the behaviour described above.

## Structure
- Package `onehot_dec_pkg`: state enum (IDLE, HOLD) and the function `onehot(code)` returning 2^N bits.
- One sub-module is natural: `onehot_dec_comb`, a pure combinational N-to-2^N decoder instantiated on the registered-data path. The top holds the FSM, counter and output registers.

## Test plan
- Reset: hold `rst_n`=0 and drive `in_valid`=1 → `out`=0000, `out_valid`=0, `in_ready`=1. Release reset → the first request is accepted on the next edge.
- Single request: `in_code`=2, HOLD=4 → `out`=0100 for exactly 4 cycles, then 0000. `in_ready`=0 during those 4 cycles.
- Sweep codes 0..3 with HOLD=1 → `out` = 0001, 0010, 0100, 1000 as single-cycle pulses, each separated by one 0000 cycle (back-to-back macro off).
- Back-to-back with `ONEHOT_DEC_BACK2BACK_EN` defined: hold `in_valid` high with code 1 then 3 → `out`=0010 for 4 cycles, immediately followed by 1000 for 4 cycles, with no gap.
- Backpressure: change `in_code` from 1 to 3 while busy without an accept → output stays 0010. The new code is accepted only when `in_ready`=1.
- Mid-hold reset: assert `rst_n`=0 on cycle 2 of HOLD → `out`=0000 before the next clock edge. State returns to IDLE.

Source files
------------

// File: rtl/onehot_dec_pkg.sv
// Shared state encoding and one-hot helper for onehot_pulse_decoder.
// States are plain logic constants so older tools and netlists read them the same way.
package onehot_dec_pkg;

  // Widest encoded index the helper supports.
  localparam int unsigned MaxN = 8;

  typedef logic state_t;

  localparam state_t StIdle = 1'b0;
  localparam state_t StHold = 1'b1;

  function automatic logic [2**MaxN-1:0] onehot(input logic [MaxN-1:0] code);
    logic [2**MaxN-1:0] vec;
    vec       = '0;
    vec[code] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/onehot_dec_comb.sv
// Pure combinational N-to-2^N decoder built on the package onehot() helper.
module onehot_dec_comb
  import onehot_dec_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]    code,
  output logic [2**N-1:0] onehot_vec
);

  logic [2**MaxN-1:0] full_vec;

  assign full_vec   = onehot(MaxN'(code));
  assign onehot_vec = full_vec[2**N-1:0];

  // Upper bits are always zero for an N-bit code.
  if (N < MaxN) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^full_vec[2**MaxN-1:2**N];
  end

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Registered one-hot strobe generator: each accepted code is shown for HOLD cycles.
// Optional ONEHOT_DEC_BACK2BACK_EN lets a new request reload on the last hold cycle.
module onehot_pulse_decoder
  import onehot_dec_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [N-1:0]    in_code,
  output logic            in_ready,
  output logic [2**N-1:0] out,
  output logic            out_valid,
  output logic            busy
);

  localparam int unsigned     CntW    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(HOLD - 1);

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2**N-1:0]   out_q, out_d;
  logic [2**N-1:0]   dec_vec;
  logic              accept;

  onehot_dec_comb #(
    .N (N)
  ) u_dec (
    .code       (in_code),
    .onehot_vec (dec_vec)
  );

`ifdef ONEHOT_DEC_BACK2BACK_EN
  assign in_ready = (state_q == StIdle) || (cnt_q == '0);
`else
  assign in_ready = (state_q == StIdle);
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    if (accept) begin
      state_d = StHold;
      cnt_d   = CntLoad;
      out_d   = dec_vec;
    end else if (state_q == StHold) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        state_d = StIdle;
        out_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign out       = out_q;
  assign out_valid = (state_q == StHold);
  assign busy      = out_valid;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Self-checking bench: HOLD=4 and HOLD=1 instances against a cycle-count reference model.
module tb_onehot_pulse_decoder;

`ifdef ONEHOT_DEC_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_code;

  logic       rdy4, ov4, busy4;
  logic [3:0] out4;
  logic       rdy1, ov1, busy1;
  logic [3:0] out1;

  int compared   = 0;
  int mismatched = 0;

  // Model: cycles the current code remains visible, per instance.
  int         rem[2];
  logic [1:0] mcode[2];
  int         hold_v[2];

  onehot_pulse_decoder #(
    .N    (2),
    .HOLD (4)
  ) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_ready  (rdy4),
    .out       (out4),
    .out_valid (ov4),
    .busy      (busy4)
  );

  onehot_pulse_decoder #(
    .N    (2),
    .HOLD (1)
  ) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_ready  (rdy1),
    .out       (out1),
    .out_valid (ov1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] exp_out(input int r, input logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return (r > 0) ? (one << c) : 4'b0000;
  endfunction

  function automatic logic exp_ready(input int r);
    return (r == 0) || (B2B && r == 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("d4.out",       32'(out4),  32'(exp_out(rem[0], mcode[0])));
    check("d4.out_valid", 32'(ov4),   32'(rem[0] > 0));
    check("d4.busy",      32'(busy4), 32'(rem[0] > 0));
    check("d4.in_ready",  32'(rdy4),  32'(exp_ready(rem[0])));
    check("d1.out",       32'(out1),  32'(exp_out(rem[1], mcode[1])));
    check("d1.out_valid", 32'(ov1),   32'(rem[1] > 0));
    check("d1.busy",      32'(busy1), 32'(rem[1] > 0));
    check("d1.in_ready",  32'(rdy1),  32'(exp_ready(rem[1])));
  endtask

  // Caller sits at a negedge: check, drive, take the posedge, land on the next negedge.
  task automatic step(input logic v, input logic [1:0] c);
    check_all();
    in_valid = v;
    in_code  = c;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (in_valid && exp_ready(rem[i])) begin
        rem[i]   = hold_v[i];
        mcode[i] = in_code;
      end else if (rem[i] > 0) begin
        rem[i]--;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    hold_v[0] = 4;
    hold_v[1] = 1;
    for (int i = 0; i < 2; i++) begin
      rem[i]   = 0;
      mcode[i] = 2'd0;
    end

    // Reset with a pending request: outputs idle, ready high.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_code  = 2'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Single request of code 2, then idle.
    step(1'b1, 2'd2);
    repeat (6) step(1'b0, 2'd0);

    // Code sweep with continuous valid.
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 2'(c));
      step(1'b1, 2'(c));
    end
    repeat (6) step(1'b0, 2'd0);

    // Backpressure: code changes while the first strobe is held.
    step(1'b1, 2'd1);
    repeat (6) step(1'b1, 2'd3);
    repeat (6) step(1'b0, 2'd0);

    // Asynchronous reset in the middle of a hold.
    step(1'b1, 2'd2);
    step(1'b0, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) rem[i] = 0;
    check("rst.d4.out", 32'(out4), 32'h0);
    check("rst.d4.out_valid", 32'(ov4), 32'h0);
    check("rst.d4.in_ready", 32'(rdy4), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'd3);
    repeat (5) step(1'b0, 2'd0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
    end
    step(1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
